// File: rtl/atomrvcore_dccm_lsu_if.sv
// MEM-stage bus between the atomRVCORE execute stage and the DCCM load/store unit.
// Requests carry no ready: a request is taken on every rising edge where it is present.
interface atomrvcore_dccm_lsu_if #(
    parameter int DATAWIDTH        = 32,
    parameter int REG_ADRESS_WIDTH = 5
);
    logic [DATAWIDTH-1:0]        address_i;
    logic                        DR_EN_i;
    logic                        DWR_EN_i;
    logic [1:0]                  size_i;
    logic                        unsigned_i;
    logic [DATAWIDTH-1:0]        DT_i;
    logic                        RWR_EN_i;
    logic [REG_ADRESS_WIDTH-1:0] RD_i;
    logic [DATAWIDTH-1:0]        WR_i;

    logic [DATAWIDTH-1:0]        DT_o;
    logic                        DVALID_o;
    logic                        MISALIGN_o;
    logic                        RWR_EN_o;
    logic [REG_ADRESS_WIDTH-1:0] RD_o;
    logic [DATAWIDTH-1:0]        WR_o;

    modport master (
        output address_i, DR_EN_i, DWR_EN_i, size_i, unsigned_i, DT_i, RWR_EN_i, RD_i, WR_i,
        input  DT_o, DVALID_o, MISALIGN_o, RWR_EN_o, RD_o, WR_o
    );

    modport slave (
        input  address_i, DR_EN_i, DWR_EN_i, size_i, unsigned_i, DT_i, RWR_EN_i, RD_i, WR_i,
        output DT_o, DVALID_o, MISALIGN_o, RWR_EN_o, RD_o, WR_o
    );
endinterface

// File: rtl/atomrvcore_dccm_lsu.sv
// Data closely-coupled memory with byte/half/word load-store lanes and the MEM/WB register.
// Loads return one cycle after issue; a same-cycle store is seen only by later loads.
module atomrvcore_dccm_lsu #(
    parameter int DATAWIDTH        = 32,
    parameter int ADDRESS_BUS      = 10,
    parameter int REG_ADRESS_WIDTH = 5
) (
    input logic                   clk_i,
    input logic                   rst_i,
    atomrvcore_dccm_lsu_if.slave  bus
);
    localparam int NB    = DATAWIDTH / 8;
    localparam int DEPTH = 1 << ADDRESS_BUS;

    logic [DATAWIDTH-1:0] mem_q [DEPTH];

    logic [ADDRESS_BUS-1:0]      idx;
    logic [1:0]                  off;
    logic                        misaligned;
    logic                        fault;
    logic                        do_load;
    logic                        do_store;
    logic [NB-1:0]               be_base;
    logic [NB-1:0]               be;
    logic [DATAWIDTH-1:0]        wdata;

    logic [DATAWIDTH-1:0]        rdata_d, rdata_q;
    logic [1:0]                  offset_d, offset_q;
    logic [1:0]                  size_d, size_q;
    logic                        unsigned_d, unsigned_q;
    logic                        load_d, load_q;
    logic                        misalign_d, misalign_q;
    logic                        rwr_en_d, rwr_en_q;
    logic [REG_ADRESS_WIDTH-1:0] rd_d, rd_q;
    logic [DATAWIDTH-1:0]        wr_d, wr_q;

    logic [DATAWIDTH-1:0]        shifted;
    logic [DATAWIDTH-1:0]        load_ext;
    logic                        unused_ok;

    always_comb begin
        idx        = bus.address_i[ADDRESS_BUS+1:2];
        off        = bus.address_i[1:0];
        misaligned = 1'b0;
        be_base    = '1;
        case (bus.size_i)
            2'b00: begin
                misaligned = 1'b0;
                be_base    = NB'(1);
            end
            2'b01: begin
                misaligned = off[0];
                be_base    = NB'(3);
            end
            2'b10: begin
                misaligned = (off != 2'b00);
                be_base    = '1;
            end
            default: begin
                misaligned = 1'b1;
                be_base    = '0;
            end
        endcase
        fault    = (bus.DR_EN_i | bus.DWR_EN_i) & misaligned;
        do_load  = bus.DR_EN_i & ~fault;
        do_store = bus.DWR_EN_i & ~fault & ~rst_i;
        be       = be_base << off;
        wdata    = bus.DT_i << {off, 3'b000};

        rdata_d    = do_load ? mem_q[idx] : rdata_q;
        offset_d   = do_load ? off : offset_q;
        size_d     = do_load ? bus.size_i : size_q;
        unsigned_d = do_load ? bus.unsigned_i : unsigned_q;
        load_d     = do_load;
        misalign_d = fault;
        rwr_en_d   = bus.RWR_EN_i & ~fault;
        rd_d       = bus.RD_i;
        wr_d       = bus.WR_i;
    end

    // Nonblocking write and read in one edge give read-before-write for a same-word pair.
    always_ff @(posedge clk_i) begin
        if (do_store) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        rdata_q    <= rdata_d;
        offset_q   <= offset_d;
        size_q     <= size_d;
        unsigned_q <= unsigned_d;
        if (rst_i) begin
            load_q     <= 1'b0;
            misalign_q <= 1'b0;
            rwr_en_q   <= 1'b0;
            rd_q       <= '0;
            wr_q       <= '0;
        end else begin
            load_q     <= load_d;
            misalign_q <= misalign_d;
            rwr_en_q   <= rwr_en_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
        end
    end

    always_comb begin
        shifted  = rdata_q >> {offset_q, 3'b000};
        load_ext = rdata_q;
        case (size_q)
            2'b00:   load_ext = {{(DATAWIDTH-8){~unsigned_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = {{(DATAWIDTH-16){~unsigned_q & shifted[15]}}, shifted[15:0]};
            default: load_ext = rdata_q;
        endcase
    end

    assign unused_ok = ^{bus.address_i, shifted[DATAWIDTH-1:16]};

    assign bus.DT_o       = load_q ? load_ext : '0;
    assign bus.DVALID_o   = load_q;
    assign bus.MISALIGN_o = misalign_q;
    assign bus.RWR_EN_o   = rwr_en_q;
    assign bus.RD_o       = rd_q;
    assign bus.WR_o       = load_q ? load_ext : wr_q;
endmodule

// File: tb/tb_atomrvcore_dccm_lsu.sv
// Directed and random checks of the DCCM load/store unit against a byte-addressed memory model.
module tb_atomrvcore_dccm_lsu;
  localparam int DW    = 32;
  localparam int AB    = 10;
  localparam int RW    = 5;
  localparam int DEPTH = 1 << AB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  atomrvcore_dccm_lsu_if #(.DATAWIDTH(DW), .REG_ADRESS_WIDTH(RW)) bus ();

  atomrvcore_dccm_lsu #(.DATAWIDTH(DW), .ADDRESS_BUS(AB), .REG_ADRESS_WIDTH(RW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  logic [7:0]    ref_mem [DEPTH*4];
  logic [DW-1:0] exp_q[$];
  int            vectors     = 0;
  int            miscompares = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned byte_addr(input logic [DW-1:0] a);
    return ((a >> 2) % DEPTH) * 4 + (a % 4);
  endfunction

  function automatic bit is_fault(input bit ld, input bit st, input logic [1:0] size,
                                  input logic [DW-1:0] a);
    if (!(ld || st)) return 1'b0;
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return (a % 2) != 0;
      2'd2:    return (a % 4) != 0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [DW-1:0] model_load(input logic [DW-1:0] a, input logic [1:0] size,
                                                input bit uns);
    int unsigned   b = byte_addr(a);
    int            n = 1 << size;
    logic [DW-1:0] v = '0;
    logic [DW-1:0] mask;
    for (int i = 0; i < n; i++) v = v | (DW'(ref_mem[b + i]) << (8 * i));
    if (!uns && n < 4 && v[8*n-1]) begin
      mask = (DW'(1) << (8 * n)) - 1;
      v = v | ~mask;
    end
    return v;
  endfunction

  task automatic drive(input bit ld, input bit st, input logic [DW-1:0] addr, input logic [1:0] size,
                       input bit uns, input logic [DW-1:0] dt, input bit rwr,
                       input logic [RW-1:0] rd, input logic [DW-1:0] wr);
    bus.address_i  = addr;
    bus.DR_EN_i    = ld;
    bus.DWR_EN_i   = st;
    bus.size_i     = size;
    bus.unsigned_i = uns;
    bus.DT_i       = dt;
    bus.RWR_EN_i   = rwr;
    bus.RD_i       = rd;
    bus.WR_i       = wr;
  endtask

  // One request per cycle: drive, let the edge take it, then check the MEM/WB outputs.
  task automatic step(input string tag, input bit ld, input bit st, input logic [DW-1:0] addr,
                      input logic [1:0] size, input bit uns, input logic [DW-1:0] dt,
                      input bit rwr, input logic [RW-1:0] rd, input logic [DW-1:0] wr);
    bit            f   = is_fault(ld, st, size, addr);
    bit            vld = ld && !f;
    int unsigned   b   = byte_addr(addr);
    logic [DW-1:0] exp_dt;
    if (vld) exp_q.push_back(model_load(addr, size, uns));
    drive(ld, st, addr, size, uns, dt, rwr, rd, wr);
    if (st && !f) begin
      for (int i = 0; i < (1 << size); i++) ref_mem[b + i] = dt[8*i +: 8];
    end
    @(posedge clk);
    #1;
    exp_dt = vld ? exp_q.pop_front() : '0;
    chk({tag, ".dt"},       bus.DT_o, exp_dt);
    chk({tag, ".dvalid"},   DW'(bus.DVALID_o), DW'(vld));
    chk({tag, ".misalign"}, DW'(bus.MISALIGN_o), DW'(f));
    chk({tag, ".rwr_en"},   DW'(bus.RWR_EN_o), DW'(rwr && !f));
    chk({tag, ".rd"},       DW'(bus.RD_o), DW'(rd));
    chk({tag, ".wr"},       bus.WR_o, vld ? exp_dt : wr);
  endtask

  task automatic reset_step(input string tag, input bit ld, input bit st,
                            input logic [DW-1:0] addr, input logic [DW-1:0] dt);
    rst = 1'b1;
    drive(ld, st, addr, 2'd2, 1'b0, dt, 1'b1, 5'd9, 32'h1234_5678);
    @(posedge clk);
    #1;
    chk({tag, ".dt"},       bus.DT_o, '0);
    chk({tag, ".dvalid"},   DW'(bus.DVALID_o), '0);
    chk({tag, ".misalign"}, DW'(bus.MISALIGN_o), '0);
    chk({tag, ".rwr_en"},   DW'(bus.RWR_EN_o), '0);
    chk({tag, ".rd"},       DW'(bus.RD_o), '0);
    chk({tag, ".wr"},       bus.WR_o, '0);
  endtask

  initial begin
    logic [DW-1:0] addr;
    logic [1:0]    size;

    drive(0, 0, '0, 2'd0, 0, '0, 0, '0, '0);
    reset_step("rst_idle", 0, 0, 32'h0, 32'h0);
    reset_step("rst_ld", 1, 0, 32'h10, 32'h0);
    rst = 1'b0;

    for (int w = 0; w < 16; w++) step("init", 0, 1, DW'(w * 4), 2'd2, 0, '0, 0, '0, '0);

    step("st_word", 0, 1, 32'h10, 2'd2, 0, 32'hDEAD_BEEF, 0, '0, '0);
    step("ld_word", 1, 0, 32'h10, 2'd2, 0, '0, 1, 5'd3, 32'h1111);
    chk("plan_word.dt", bus.DT_o, 32'hDEAD_BEEF);
    chk("plan_word.wr", bus.WR_o, 32'hDEAD_BEEF);

    step("st_byte", 0, 1, 32'h13, 2'd0, 0, 32'h80, 0, '0, '0);
    step("ld_sbyte", 1, 0, 32'h13, 2'd0, 0, '0, 1, 5'd4, '0);
    chk("plan_sbyte", bus.DT_o, 32'hFFFF_FF80);
    step("ld_ubyte", 1, 0, 32'h13, 2'd0, 1, '0, 1, 5'd4, '0);
    chk("plan_ubyte", bus.DT_o, 32'h0000_0080);
    step("ld_word2", 1, 0, 32'h10, 2'd2, 0, '0, 1, 5'd4, '0);
    chk("plan_word2", bus.DT_o, 32'h80AD_BEEF);

    step("st_mis", 0, 1, 32'h11, 2'd1, 0, 32'h1234, 1, 5'd5, 32'h77);
    chk("plan_mis.misalign", DW'(bus.MISALIGN_o), 32'h1);
    chk("plan_mis.rwr_en", DW'(bus.RWR_EN_o), 32'h0);
    step("idle", 0, 0, '0, 2'd0, 0, '0, 0, '0, '0);
    chk("plan_mis_pulse", DW'(bus.MISALIGN_o), 32'h0);
    step("ld_word3", 1, 0, 32'h10, 2'd2, 0, '0, 0, '0, '0);
    chk("plan_unchanged", bus.DT_o, 32'h80AD_BEEF);
    step("ld_shalf", 1, 0, 32'h12, 2'd1, 0, '0, 0, '0, '0);
    chk("plan_shalf", bus.DT_o, 32'hFFFF_80AD);

    step("ld_st_same", 1, 1, 32'h20, 2'd2, 0, 32'h55, 0, '0, '0);
    chk("plan_rbw", bus.DT_o, 32'h0);
    step("ld_after", 1, 0, 32'h20, 2'd2, 0, '0, 0, '0, '0);
    chk("plan_after", bus.DT_o, 32'h55);

    step("ld_alias", 1, 0, 32'h1010, 2'd2, 0, '0, 0, '0, '0);
    chk("plan_alias", bus.DT_o, 32'h80AD_BEEF);
    step("alu_wb", 0, 0, 32'h40, 2'd2, 0, '0, 1, 5'd7, 32'hA5);
    chk("plan_alu.wr", bus.WR_o, 32'hA5);
    chk("plan_alu.dvalid", DW'(bus.DVALID_o), 32'h0);

    reset_step("rst_mid", 1, 1, 32'h10, 32'hCAFE_F00D);
    rst = 1'b0;
    step("post_rst", 0, 0, '0, 2'd0, 0, '0, 0, '0, '0);
    step("ld_post", 1, 0, 32'h10, 2'd2, 0, '0, 0, '0, '0);
    chk("plan_rst_store", bus.DT_o, 32'h80AD_BEEF);

    for (int k = 0; k < 400; k++) begin
      addr = ($urandom & 32'hFFFF_F000) | DW'($urandom_range(0, 15) << 2) | DW'($urandom_range(0, 3));
      size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr, size,
           1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
           RW'($urandom), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/atomrvcore_dccm_lsu.md
# atomrvcore_dccm_lsu

Parametrised data closely-coupled memory with an integrated load/store lane unit for the atomRVCORE pipeline, sitting in the MEM stage between execute and register writeback. It adds byte/half/word stores with byte enables, sign- or zero-extended sub-word loads, misalignment detection, and a synchronous registered read that is aligned with the MEM/WB pipeline register. The MEM/WB register selects load data or the ALU result for writeback.

## Interface
- DATAWIDTH, 32, data and address bus width; multiple of 32 (lanes are bytes)
- ADDRESS_BUS, 10, word-index bits; depth = 2**ADDRESS_BUS words
- REG_ADRESS_WIDTH, 5, destination register index width
- clk_i  in  1  single clock, all state on rising edge
- rst_i  in  1  reset, synchronous, active-high
- address_i  in  DATAWIDTH  byte address
- DR_EN_i  in  1  load request
- DWR_EN_i  in  1  store request
- size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- unsigned_i  in  1  1 = zero-extend load, 0 = sign-extend
- DT_i  in  DATAWIDTH  store data, LSB-justified
- RWR_EN_i  in  1  register write enable from EX
- RD_i  in  REG_ADRESS_WIDTH  destination register
- WR_i  in  DATAWIDTH  ALU result
- DT_o  out  DATAWIDTH  extended load data
- DVALID_o  out  1  DT_o valid (load completed)
- MISALIGN_o  out  1  previous-cycle access faulted
- RWR_EN_o  out  1  registered write enable to WB
- RD_o  out  REG_ADRESS_WIDTH  registered destination
- WR_o  out  DATAWIDTH  writeback data: load data if load, else ALU result

## Operation
- Word index = address_i[ADDRESS_BUS+1:2]; offset = address_i[1:0]; higher address bits are ignored (wrap modulo depth).
- Fault when size_i=11, half with offset[0]=1, or word with offset!=0, and DR_EN_i|DWR_EN_i is high. A faulting store writes nothing. A faulting load does not assert DVALID_o.
- Store: DT_i is shifted left by 8*offset. The byte-enable mask is 0001/0011/1111 shifted by offset. Only enabled bytes of the addressed word change.
- Load: the word is read synchronously into rdata_q. offset_q, size_q, unsigned_q, and load_q are registered with it.
- DT_o is combinational from these registers: extract the byte or half at offset_q, then sign- or zero-extend to DATAWIDTH. For a word load, DT_o equals rdata_q.
- DT_o = 0 when DVALID_o = 0.
- DR_EN_i and DWR_EN_i both high, same or different word: the store is performed and the load returns the pre-store contents (read-before-write).
- MEM/WB register:
  - RWR_EN_o <= RWR_EN_i & ~fault.
  - RD_o <= RD_i.
  - WR_o = load_q ? DT_o : wr_q, where wr_q <= WR_i.
- MISALIGN_o <= fault, a one-cycle pulse per faulting request.
- Memory contents are not reset.

## Timing
- Store: committed at the rising edge where DWR_EN_i=1. It is visible to a load issued in the next cycle.
- Load: issued at cycle N. DT_o, DVALID_o, and WR_o are valid in cycle N+1. Latency is exactly 1; loads are accepted back-to-back every cycle.
- Reset: while rst_i=1 at the edge, DT_o=0, DVALID_o=0, MISALIGN_o=0, RWR_EN_o=0, RD_o=0, WR_o=0, and load_q=0. A load issued in the cycle reset is asserted is dropped. A store in that cycle is suppressed.
- The first request is accepted on the first edge with rst_i=0.
- No stall or backpressure input; every request completes in fixed time.

## Test plan
- Word store 0xDEADBEEF at 0x10, word load at 0x10 next cycle -> DT_o=0xDEADBEEF, DVALID_o=1 at N+1, WR_o=0xDEADBEEF.
- Byte store 0x80 at 0x13 over that word, then signed byte load 0x13 -> 0xFFFFFF80. Unsigned -> 0x00000080. Word load -> 0x80ADBEEF.
- Half store 0x1234 at 0x11 -> MISALIGN_o=1 for one cycle, RWR_EN_o=0, word at 0x10 unchanged. Half load at 0x12 -> signed 0xFFFF80AD.
- Load and store the same word in one cycle (old 0x0, store 0x55) -> DT_o=0x0. Load next cycle -> 0x55.
- Address 0x1010 with ADDRESS_BUS=10 -> aliases word 0x10. Non-load with RWR_EN_i=1, WR_i=0xA5 -> WR_o=0xA5, DVALID_o=0.
- rst_i=1 during an issued load -> all outputs 0 next cycle, DVALID_o never asserted for that load.
